// File: rtl/addsub_serial_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Imported by the top module.
package addsub_serial_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage : addsub_serial_pkg

// File: rtl/addsub_serial_fa_cell.sv
// Single full-adder cell.
// The serial add/sub reuses it once per result bit.
module serial_fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : serial_fa_cell

// File: rtl/addsub_serial.sv
// Bit-serial signed adder/subtractor, LSB first, with one full-adder cell and a carry flop.
// The result is N+2 bits wide, so the sum of two sign-extended N+1-bit operands can never overflow.
module addsub_serial
   import addsub_serial_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N:0]   x,
   input  logic [N:0]   y,
   input  logic         sel,
   output logic         busy,
   output logic         done,
   output logic [N+1:0] z
);

   localparam int W  = N + 2;
   localparam int CW = $clog2(N + 2);

   state_t         state;
   state_t         state_nxt;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [W-2:0]   res_q;
   logic           carry_q;
   logic           sel_q;
   logic [CW-1:0]  cnt_q;

   logic           load;
   logic           last;
   logic           fa_b;
   logic           fa_s;
   logic           fa_cout;

   // The DONE cycle also accepts a new start, so back-to-back operations lose no cycle.
   assign load = start && ((state == IDLE) || (state == DONE));
   assign last = (state == RUN) && (cnt_q == CW'(N + 1));
   assign fa_b = b_q[0] ^ (sel_q == OP_SUB);

   serial_fa_cell u_fa (
      .a    (a_q[0]),
      .b    (fa_b),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_cout)
   );

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN) || (state == DONE);
      done = (state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         sel_q   <= OP_ADD;
         cnt_q   <= '0;
         z       <= '0;
      end else if (load) begin
         a_q     <= {x[N], x};
         b_q     <= {y[N], y};
         carry_q <= sel;
         sel_q   <= sel;
         cnt_q   <= '0;
      end else if (state == RUN) begin
         a_q     <= {1'b0, a_q[W-1:1]};
         b_q     <= {1'b0, b_q[W-1:1]};
         res_q   <= {fa_s, res_q[W-2:1]};
         carry_q <= fa_cout;
         cnt_q   <= cnt_q + 1'b1;
         // The final sum bit goes straight into z; the carry out of the MSB is discarded.
         if (last) z <= {fa_s, res_q};
      end
   end

endmodule : addsub_serial

// File: tb/tb_addsub_serial.sv
// Directed and exhaustive checks for the bit-serial add/sub at N=4.
// Expected results are hand-computed constants or signed arithmetic on the operands.
module tb_addsub_serial;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [N:0]   x = '0;
   logic [N:0]   y = '0;
   logic         sel = 1'b0;
   logic         busy;
   logic         done;
   logic [N+1:0] z;

   int tests = 0;
   int fails = 0;

   addsub_serial #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .x     (x),
      .y     (y),
      .sel   (sel),
      .busy  (busy),
      .done  (done),
      .z     (z)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] ref_z(input logic [4:0] a, input logic [4:0] b, input logic s);
      logic signed [5:0] sa;
      logic signed [5:0] sb;
      sa = signed'({a[4], a});
      sb = signed'({b[4], b});
      return s ? 6'(sa - sb) : 6'(sa + sb);
   endfunction

   // One operation from an idle DUT; reports result, edges to done, and busy-high cycles.
   task automatic do_op(input logic [4:0] xa, input logic [4:0] ya, input logic s,
                        output logic [5:0] zo, output int lat, output int bcnt);
      logic [5:0] zprev;
      int guard;
      guard = 0;
      @(negedge clk);
      while (busy && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      zprev = z;
      x = xa; y = ya; sel = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      bcnt = busy ? 1 : 0;
      while (!done && lat < 20) begin
         tests++;
         if (z !== zprev) begin
            fails++;
            $display("FAIL z_hold: z=%b mid-run, required held %b", z, zprev);
         end
         @(posedge clk); #1;
         lat++;
         if (busy) bcnt++;
      end
      zo = z;
      @(posedge clk); #1;
      if (busy) bcnt++;
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL done_pulse: done=%b one cycle after done, required 0", done);
      end
   endtask

   task automatic test_reset();
      #3;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || z !== 6'b0) begin
         fails++;
         $display("FAIL reset: busy=%b done=%b z=%b, required 0 0 000000", busy, done, z);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add_basic();
      logic [5:0] zo;
      int lat, bcnt;
      do_op(5'd2, 5'd2, 1'b0, zo, lat, bcnt);
      tests++;
      if (zo !== 6'b000100) begin
         fails++;
         $display("FAIL add_2_2: z=%b, required 000100", zo);
      end
      tests++;
      if (lat !== 6) begin
         fails++;
         $display("FAIL latency: done after %0d edges, required 6", lat);
      end
      tests++;
      if (bcnt !== 7) begin
         fails++;
         $display("FAIL busy_len: busy high %0d cycles, required 7", bcnt);
      end
   endtask

   task automatic test_vectors();
      logic [5:0] zo;
      int lat, bcnt;
      do_op(5'd0, 5'd2, 1'b1, zo, lat, bcnt);
      tests++;
      if (zo !== 6'b111110) begin
         fails++;
         $display("FAIL sub_0_2: z=%b, required 111110", zo);
      end
      do_op(5'd15, 5'd15, 1'b0, zo, lat, bcnt);
      tests++;
      if (zo !== 6'b011110) begin
         fails++;
         $display("FAIL add_15_15: z=%b, required 011110", zo);
      end
      do_op(5'b10000, 5'd15, 1'b1, zo, lat, bcnt);
      tests++;
      if (zo !== 6'b100001) begin
         fails++;
         $display("FAIL sub_m16_15: z=%b, required 100001", zo);
      end
      do_op(5'b10000, 5'b10000, 1'b0, zo, lat, bcnt);
      tests++;
      if (zo !== 6'b100000) begin
         fails++;
         $display("FAIL add_m16_m16: z=%b, required 100000", zo);
      end
      // z must stay put while idle
      repeat (4) @(posedge clk);
      #1;
      tests++;
      if (z !== 6'b100000 || done !== 1'b0) begin
         fails++;
         $display("FAIL idle_hold: z=%b done=%b, required 100000 0", z, done);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge clk);
      x = 5'd3; y = 5'd1; sel = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      x = 5'd9; y = 5'd2; sel = 1'b1;
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      tests++;
      if (lat !== 6 || z !== 6'b000100) begin
         fails++;
         $display("FAIL b2b_first: edges=%0d z=%b, required 6 000100", lat, z);
      end
      @(posedge clk); #1;
      start = 1'b0;
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         fails++;
         $display("FAIL b2b_restart: busy=%b done=%b at edge k+7, required 1 0", busy, done);
      end
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      tests++;
      if (lat !== 6 || z !== 6'b000111) begin
         fails++;
         $display("FAIL b2b_second: edges=%0d z=%b, required 6 000111", lat, z);
      end
   endtask

   task automatic test_reset_mid();
      logic [5:0] zo;
      int lat, bcnt;
      int saw_done;
      @(negedge clk);
      while (busy) @(negedge clk);
      x = 5'd5; y = 5'd3; sel = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if (busy !== 1'b0 || z !== 6'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: busy=%b z=%b done=%b, required 0 000000 0", busy, z, done);
      end
      @(negedge clk);
      rst = 1'b0;
      saw_done = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done) saw_done++;
      end
      tests++;
      if (saw_done !== 0) begin
         fails++;
         $display("FAIL reset_no_done: %0d done pulses after reset, required 0", saw_done);
      end
      do_op(5'd5, 5'd3, 1'b0, zo, lat, bcnt);
      tests++;
      if (zo !== 6'b001000) begin
         fails++;
         $display("FAIL after_reset: z=%b, required 001000", zo);
      end
   endtask

   task automatic test_sweep();
      logic [5:0] zo;
      logic [5:0] exp_z;
      int lat, bcnt;
      for (int xi = 0; xi < 32; xi++) begin
         for (int yi = 0; yi < 32; yi++) begin
            for (int si = 0; si < 2; si++) begin
               do_op(5'(xi), 5'(yi), 1'(si), zo, lat, bcnt);
               exp_z = ref_z(5'(xi), 5'(yi), 1'(si));
               tests++;
               if (zo !== exp_z || lat !== 6) begin
                  fails++;
                  $display("FAIL sweep x=%0d y=%0d sel=%0d: z=%b edges=%0d, required %b 6",
                           xi, yi, si, zo, lat, exp_z);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_add_basic();
      test_vectors();
      test_back_to_back();
      test_reset_mid();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_addsub_serial
